// File: rtl/fa4_serial.sv
// fa4_serial: bit-serial adder computing {co,s} = a + b + ci, one full-adder step per clock, LSB first
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   start - begin an addition (accepted only when not busy)
//   a, b  - WIDTH-bit operands, ci - carry-in; latched when start is accepted
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when s/co have just been loaded
//   s, co - registered sum and carry-out of the last completed addition
module fa4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, r;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             sb, nc;
  assign sb = a_sh[0] ^ b_sh[0] ^ c;
  assign nc = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
  // sum bits enter r from the MSB end, so after WIDTH steps bit 0 holds the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= nc;
          r    <= {sb, r[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= {sb, r[WIDTH-1:1]};
            co    <= nc;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= ci;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fa4_serial.sv
// tb_fa4_serial: directed self-checking bench for fa4_serial (WIDTH=4)
module tb_fa4_serial;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       ci = 1'b0;
  logic       busy, done, co;
  logic [3:0] s;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         t1, t2;
  logic [4:0] last = '0;

  fa4_serial #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // starts an op at the current time, checks the 4 busy cycles, returns in the done cycle
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic z);
    logic [4:0] e;
    e = 5'(x) + 5'(y) + 5'(z);
    a = x; b = y; ci = z; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("busy", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      chk("hold", 32'({co, s}), 32'(last));
      @(negedge clk);
    end
    chk("done", 32'(done), 1);
    chk("busy_off", 32'(busy), 0);
    chk("sum", 32'({co, s}), 32'(e));
    last = e;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_timeout", 32'(seen), 1);
  endtask

  initial begin
    #3;
    chk("rst_s", 32'({co, s}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // basic: 3+5
    run_op(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    // back-to-back: 15+15+1 then 15+1 started in the done cycle
    run_op(4'd15, 4'd15, 1'b1);
    t1 = cyc;
    run_op(4'd15, 4'd1, 1'b0);
    t2 = cyc;
    chk("b2b_gap", 32'(t2 - t1), 5);
    @(negedge clk);
    // start during RUN is ignored
    a = 4'd2; b = 4'd2; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd9; b = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("ignore_sum", 32'({co, s}), 32'd4);
    @(negedge clk);
    chk("ignore_no_rerun", 32'(busy), 0);
    last = 5'd4;
    // operands scrambled during RUN: 6+7+1
    a = 4'd6; b = 4'd7; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
      @(negedge clk);
    end
    wait_done();
    chk("latched_sum", 32'({co, s}), 32'd14);
    @(negedge clk);
    // reset mid-RUN after a result of 8
    last = 5'd14;
    run_op(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    a = 4'd7; b = 4'd7; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s", 32'({co, s}), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_s", 32'({co, s}), 0);
    end
    // start right after a reset release is accepted at the next edge
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    last = 5'd0;
    run_op(4'd1, 4'd1, 1'b0);
    // exhaustive back-to-back
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run_op(v[7:4], v[3:0], v[8]);
    end
    @(negedge clk);
    chk("final_idle_done", 32'(done), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fa4_serial.md
FA4_SERIAL -- requirements
Module: fa4_serial

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, operand/sum width in bits; all behaviour below is stated for a general WIDTH of at least 2.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n SHALL be: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port start SHALL be: start  input  1  request to begin an addition; sampled at rising clk edges.
REQ-005 Port a SHALL be: a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 Port b SHALL be: b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 Port ci SHALL be: ci  input  1  carry-in; sampled only when start is accepted.
REQ-008 Port busy SHALL be: busy  output  1  high while an addition is in progress.
REQ-009 Port done SHALL be: done  output  1  one-cycle pulse marking that s/co were just updated.
REQ-010 Port s SHALL be: s  output  WIDTH  registered sum of the last completed addition.
REQ-011 Port co SHALL be: co  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL compute {co,s} = a + b + ci bit-serially, LSB first, using exactly one 1-bit full-adder evaluation per clock cycle.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 Transitions: IDLE->RUN on an accepted start; RUN->RUN while bit counter < WIDTH-1; RUN->DONE after bit WIDTH-1 is processed; DONE->RUN on an accepted start, else DONE->IDLE.
REQ-015 Start SHALL be accepted only in IDLE or DONE; on acceptance a, b and ci SHALL be latched into internal shift registers and a carry register, and the bit counter SHALL be cleared.
REQ-016 Start asserted in RUN SHALL be ignored: no relatch of operands, no change to progress or outputs.
REQ-017 In each RUN cycle the block SHALL produce sum bit = a_sh[0]^b_sh[0]^c and next carry = majority(a_sh[0],b_sh[0],c), shift the sum bit into an internal result register from the MSB end, shift both operand registers right by one, and increment the counter.
REQ-018 Latency: for start accepted at edge E0, bits SHALL be processed at edges E1..E_WIDTH, s/co SHALL be loaded at edge E_WIDTH, and done SHALL be high for exactly the cycle following E_WIDTH.
REQ-019 busy SHALL be high from edge E0 up to edge E_WIDTH, and low in IDLE and DONE.
REQ-020 s and co SHALL hold the previous result throughout RUN and SHALL change only at the completion edge.
REQ-021 Back-to-back operation: a start accepted in DONE SHALL begin the next addition with no idle gap, giving a throughput of one result every WIDTH+1 cycles.
REQ-022 Operand inputs a, b and ci SHALL NOT affect the computation after acceptance, even if they change during RUN.
REQ-023 co SHALL equal bit WIDTH of the full (WIDTH+1)-bit sum; wrap-around of s SHALL occur with no saturation.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately, independent of clk, force the state to IDLE and clear busy, done, s, co, the counter and all internal registers to 0.
REQ-025 Reset during RUN SHALL abandon the operation, with no done pulse and no partial update of s/co after release.
REQ-026 After rst_n deasserts, the first start SHALL be acceptable at the next rising edge.

Verification
REQ-027 Scenario: a=3, b=5, ci=0, start one cycle -> busy high for 4 cycles, then done pulse with s=8, co=0.
REQ-028 Scenario: a=15, b=15, ci=1 -> s=15, co=1; then a=15, b=1, ci=0 started in the DONE cycle -> s=0, co=1 exactly 5 cycles after the first done.
REQ-029 Scenario: start a=2, b=2, ci=0, then assert start with a=9, b=9 on the 2nd RUN cycle -> second start is ignored and the result is s=4, co=0.
REQ-030 Scenario: rst_n pulsed low mid-RUN after a prior result s=8 -> s=0, co=0, busy=0 immediately, and no done pulse follows.
REQ-031 Scenario: operands changed every cycle during RUN -> the result matches the values latched at start.
REQ-032 Scenario: exhaustive run of all 512 {ci,a,b} combinations back-to-back -> every {co,s} equals a+b+ci, with exactly one done per operation.
